// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions for the core-side bus master: widths, active-low
// levels, transfer direction values and master FSM state encodings.
`timescale 1ns/1ps
package bus_master_if_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  // Bus handshake lines are active-low
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_STALL  = 2'd3;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
  } bus_cmd_t;

  localparam bus_cmd_t CMD_RESET = '{rw: READ, addr: '0, wr_data: '0};

  function automatic logic is_active(input logic level_);
    return level_ == ENABLE_;
  endfunction

endpackage

// File: rtl/bus_master_if.sv
// Core-side bus master: requests the shared bus, issues one strobed access,
// returns read data to the core and aborts with an error pulse on timeout.
`timescale 1ns/1ps
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_stall,
  input  logic              cpu_flush,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_busy,
  output logic              cpu_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        r_state;
  bus_cmd_t          r_cmd;
  logic              r_bus_req_;
  logic              r_bus_as_;
  logic [DATA_W-1:0] r_rd_buf;
  logic [7:0]        r_cnt;
  logic              r_cpu_err;

  logic              w_grnt;
  logic              w_rdy;
  logic              w_accept;
  logic              w_busy;
  logic [DATA_W-1:0] w_rd_data;

  assign w_grnt = is_active(bus_grnt_);
  assign w_rdy  = is_active(bus_rdy_);

  // The error cycle doubles as the mandatory idle gap, so nothing is taken then
  assign w_accept = (r_state == S_IDLE) && cpu_req && !cpu_flush && !r_cpu_err;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_RESET;
      r_bus_req_ <= DISABLE_;
      r_bus_as_  <= DISABLE_;
      r_rd_buf   <= '0;
      r_cnt      <= '0;
      r_cpu_err  <= 1'b0;
    end else begin
      r_bus_as_ <= DISABLE_;
      r_cpu_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd      <= '{rw: cpu_rw, addr: cpu_addr, wr_data: cpu_wr_data};
            r_bus_req_ <= ENABLE_;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (cpu_flush) begin
            r_bus_req_ <= DISABLE_;
            r_state    <= S_IDLE;
          end else if (w_grnt) begin
            r_bus_as_ <= ENABLE_;
            r_cnt     <= '0;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_rdy) begin
            if (r_cmd.rw == READ) r_rd_buf <= bus_rd_data;
            r_bus_req_ <= DISABLE_;
            r_state    <= cpu_stall ? S_STALL : S_IDLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cpu_err  <= 1'b1;
            r_bus_req_ <= DISABLE_;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STALL: begin
          if (!cpu_stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_busy    = 1'b0;
    w_rd_data = '0;
    case (r_state)
      S_IDLE:   w_busy = w_accept;
      S_REQ:    w_busy = 1'b1;
      S_ACCESS: begin
        w_busy = !w_rdy;
        if (w_rdy) w_rd_data = bus_rd_data;
      end
      S_STALL:  w_rd_data = r_rd_buf;
      default:  w_busy = 1'b0;
    endcase
  end

  assign cpu_busy    = w_busy;
  assign cpu_rd_data = w_rd_data;
  assign cpu_err     = r_cpu_err;
  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_cmd.rw;
  assign bus_addr    = r_cmd.addr;
  assign bus_wr_data = r_cmd.wr_data;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: bench-side arbiter/slave stimulus
// with a scoreboard of expected transactions checked at completion.
`timescale 1ns/1ps
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_rw;
  logic [29:0]       cpu_addr;
  logic [31:0]       cpu_wr_data;
  logic              cpu_stall;
  logic              cpu_flush;
  logic [31:0]       cpu_rd_data;
  logic              cpu_busy;
  logic              cpu_err;
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [29:0]       bus_addr;
  logic [31:0]       bus_wr_data;
  logic [31:0]       bus_rd_data;
  logic              bus_rdy_;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_master_if #(.TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_stall   (cpu_stall),
    .cpu_flush   (cpu_flush),
    .cpu_rd_data (cpu_rd_data),
    .cpu_busy    (cpu_busy),
    .cpu_err     (cpu_err),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req     = 1'b0;
    cpu_rw      = 1'b1;
    cpu_addr    = '0;
    cpu_wr_data = '0;
    cpu_stall   = 1'b0;
    cpu_flush   = 1'b0;
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'b1;
    bus_rd_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) next_cycle();
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL rst_req got=%b want=1", bus_req_); end
    total++; if (bus_as_ !== 1'b1) begin bad++; $display("FAIL rst_as got=%b want=1", bus_as_); end
    total++; if (bus_rw !== 1'b1) begin bad++; $display("FAIL rst_rw got=%b want=1", bus_rw); end
    total++; if (bus_addr !== 30'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus_addr); end
    total++; if (bus_wr_data !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", bus_wr_data); end
    total++; if (cpu_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", cpu_err); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", cpu_busy); end
    total++; if (cpu_rd_data !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", cpu_rd_data); end
    next_cycle();
    reset = 1'b0;
  endtask

  // Read with grant on the 2nd REQ cycle and ready on the 3rd ACCESS cycle
  task automatic test_read();
    exp_t e;
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h100;
    sb_q.push_back('{rw: 1'b1, addr: 30'h100, data: 32'hDEADBEEF});
    sample();
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL rd_idle_busy got=%b want=1", cpu_busy); end
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL rd_idle_req got=%b want=1", bus_req_); end
    next_cycle();
    cpu_req = 1'b0;
    sample();
    total++; if (bus_req_ !== 1'b0) begin bad++; $display("FAIL rd_req1 got=%b want=0", bus_req_); end
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL rd_req1_busy got=%b want=1", cpu_busy); end
    next_cycle();
    bus_grnt_ = 1'b0;
    sample();
    total++; if (bus_as_ !== 1'b1) begin bad++; $display("FAIL rd_req2_as got=%b want=1", bus_as_); end
    next_cycle();
    bus_grnt_ = 1'b1;
    sample();
    e = sb_q[0];
    total++; if (bus_as_ !== 1'b0) begin bad++; $display("FAIL rd_acc1_as got=%b want=0", bus_as_); end
    total++; if (bus_addr !== e.addr) begin bad++; $display("FAIL rd_addr got=%h want=%h", bus_addr, e.addr); end
    total++; if (bus_rw !== e.rw) begin bad++; $display("FAIL rd_rw got=%b want=%b", bus_rw, e.rw); end
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL rd_acc1_busy got=%b want=1", cpu_busy); end
    next_cycle();
    sample();
    total++; if (bus_as_ !== 1'b1) begin bad++; $display("FAIL rd_acc2_as got=%b want=1", bus_as_); end
    total++; if (bus_req_ !== 1'b0) begin bad++; $display("FAIL rd_acc2_req got=%b want=0", bus_req_); end
    next_cycle();
    bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    sample();
    e = sb_q.pop_front();
    total++; if (cpu_rd_data !== e.data) begin bad++; $display("FAIL rd_data got=%h want=%h", cpu_rd_data, e.data); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL rd_done_busy got=%b want=0", cpu_busy); end
    next_cycle();
    bus_rdy_ = 1'b1; bus_rd_data = '0;
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL rd_release got=%b want=1", bus_req_); end
    total++; if (cpu_rd_data !== 32'h0) begin bad++; $display("FAIL rd_idle_data got=%h want=0", cpu_rd_data); end
  endtask

  task automatic test_write();
    exp_t e;
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 30'h40; cpu_wr_data = 32'h12345678;
    bus_grnt_ = 1'b0;
    sb_q.push_back('{rw: 1'b0, addr: 30'h40, data: 32'h12345678});
    sample();
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL wr_idle_busy got=%b want=1", cpu_busy); end
    next_cycle();
    cpu_req = 1'b0; cpu_wr_data = '0;
    sample();
    total++; if (bus_req_ !== 1'b0) begin bad++; $display("FAIL wr_req got=%b want=0", bus_req_); end
    next_cycle();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0;
    sample();
    e = sb_q.pop_front();
    total++; if (bus_as_ !== 1'b0) begin bad++; $display("FAIL wr_as got=%b want=0", bus_as_); end
    total++; if (bus_rw !== e.rw) begin bad++; $display("FAIL wr_rw got=%b want=%b", bus_rw, e.rw); end
    total++; if (bus_addr !== e.addr) begin bad++; $display("FAIL wr_addr got=%h want=%h", bus_addr, e.addr); end
    total++; if (bus_wr_data !== e.data) begin bad++; $display("FAIL wr_data got=%h want=%h", bus_wr_data, e.data); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL wr_done_busy got=%b want=0", cpu_busy); end
    next_cycle();
    bus_rdy_ = 1'b1;
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL wr_release got=%b want=1", bus_req_); end
    total++; if (bus_as_ !== 1'b1) begin bad++; $display("FAIL wr_as_end got=%b want=1", bus_as_); end
  endtask

  // Flush arrives together with the grant and must win
  task automatic test_flush();
    logic as_seen;
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h200;
    next_cycle();
    cpu_req = 1'b0; cpu_flush = 1'b1; bus_grnt_ = 1'b0;
    sample();
    total++; if (bus_req_ !== 1'b0) begin bad++; $display("FAIL fl_req got=%b want=0", bus_req_); end
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL fl_req_busy got=%b want=1", cpu_busy); end
    next_cycle();
    cpu_flush = 1'b0; bus_grnt_ = 1'b1;
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL fl_release got=%b want=1", bus_req_); end
    total++; if (bus_as_ !== 1'b1) begin bad++; $display("FAIL fl_as got=%b want=1", bus_as_); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL fl_busy got=%b want=0", cpu_busy); end
    as_seen = 1'b0;
    bus_grnt_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      if (bus_as_ !== 1'b1 || bus_req_ !== 1'b1) as_seen = 1'b1;
    end
    bus_grnt_ = 1'b1;
    total++; if (as_seen !== 1'b0) begin bad++; $display("FAIL fl_quiet got=%b want=0", as_seen); end
  endtask

  task automatic test_stall();
    exp_t e;
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h300;
    sb_q.push_back('{rw: 1'b1, addr: 30'h300, data: 32'hCAFEF00D});
    next_cycle();
    cpu_req = 1'b0; bus_grnt_ = 1'b0;
    next_cycle();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D; cpu_stall = 1'b1;
    sample();
    e = sb_q.pop_front();
    total++; if (cpu_rd_data !== e.data) begin bad++; $display("FAIL st_done_data got=%h want=%h", cpu_rd_data, e.data); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL st_done_busy got=%b want=0", cpu_busy); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD0BAD;
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 30'h3FF;
      sample();
      total++; if (cpu_rd_data !== e.data) begin bad++; $display("FAIL st_hold%0d got=%h want=%h", i, cpu_rd_data, e.data); end
      total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL st_busy%0d got=%b want=0", i, cpu_busy); end
      total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL st_req%0d got=%b want=1", i, bus_req_); end
    end
    next_cycle();
    cpu_stall = 1'b0; cpu_req = 1'b0;
    sample();
    total++; if (cpu_rd_data !== e.data) begin bad++; $display("FAIL st_last got=%h want=%h", cpu_rd_data, e.data); end
    next_cycle();
    bus_rd_data = '0;
    sample();
    total++; if (cpu_rd_data !== 32'h0) begin bad++; $display("FAIL st_idle_data got=%h want=0", cpu_rd_data); end
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL st_idle_req got=%b want=1", bus_req_); end
    next_cycle();
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL st_no_leak got=%b want=1", bus_req_); end
  endtask

  task automatic test_timeout();
    int   n_access;
    logic done;
    logic err_early;
    logic busy_drop;
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h500;
    next_cycle();
    cpu_req = 1'b0; bus_grnt_ = 1'b0;
    next_cycle();
    bus_grnt_ = 1'b1;
    sample();
    total++; if (bus_as_ !== 1'b0) begin bad++; $display("FAIL to_as got=%b want=0", bus_as_); end
    n_access = 1; done = 1'b0; err_early = 1'b0; busy_drop = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      next_cycle();
      sample();
      if (bus_req_ === 1'b1) done = 1'b1;
      else begin
        n_access++;
        if (cpu_err !== 1'b0) err_early = 1'b1;
        if (cpu_busy !== 1'b1) busy_drop = 1'b1;
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL to_bound got=%0d cycles want=release", n_access); end
    total++; if (n_access != 255) begin bad++; $display("FAIL to_len got=%0d want=255", n_access); end
    total++; if (err_early !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", err_early); end
    total++; if (busy_drop !== 1'b0) begin bad++; $display("FAIL to_busy_acc got=%b want=0", busy_drop); end
    total++; if (cpu_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", cpu_err); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b want=0", cpu_busy); end
    total++; if (cpu_rd_data !== 32'h0) begin bad++; $display("FAIL to_data got=%h want=0", cpu_rd_data); end
    next_cycle();
    sample();
    total++; if (cpu_err !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b want=0", cpu_err); end
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL to_idle_req got=%b want=1", bus_req_); end
  endtask

  task automatic test_reset_mid_access();
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 30'h7; cpu_wr_data = 32'hA5A5A5A5;
    sb_q.push_back('{rw: 1'b0, addr: 30'h7, data: 32'hA5A5A5A5});
    next_cycle();
    cpu_req = 1'b0; bus_grnt_ = 1'b0;
    next_cycle();
    bus_grnt_ = 1'b1;
    sample();
    total++; if (bus_as_ !== 1'b0) begin bad++; $display("FAIL rm_as got=%b want=0", bus_as_); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h55AA55AA;
    sb_q.delete();
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL rm_req got=%b want=1", bus_req_); end
    total++; if (bus_as_ !== 1'b1) begin bad++; $display("FAIL rm_as_off got=%b want=1", bus_as_); end
    total++; if (bus_rw !== 1'b1) begin bad++; $display("FAIL rm_rw got=%b want=1", bus_rw); end
    total++; if (bus_addr !== 30'h0) begin bad++; $display("FAIL rm_addr got=%h want=0", bus_addr); end
    total++; if (bus_wr_data !== 32'h0) begin bad++; $display("FAIL rm_wdata got=%h want=0", bus_wr_data); end
    total++; if (cpu_err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b want=0", cpu_err); end
    total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", cpu_busy); end
    total++; if (cpu_rd_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h want=0", cpu_rd_data); end
    next_cycle();
    bus_rdy_ = 1'b1; bus_rd_data = '0;
  endtask

  // Request held high across completion: an idle gap must separate the two
  task automatic test_back_to_back();
    exp_t e;
    next_cycle();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h600;
    sb_q.push_back('{rw: 1'b1, addr: 30'h600, data: 32'h11111111});
    next_cycle();
    bus_grnt_ = 1'b0;
    next_cycle();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h11111111;
    sample();
    e = sb_q.pop_front();
    total++; if (cpu_rd_data !== e.data) begin bad++; $display("FAIL bb_data1 got=%h want=%h", cpu_rd_data, e.data); end
    next_cycle();
    bus_rdy_ = 1'b1; bus_rd_data = '0; cpu_addr = 30'h604;
    sb_q.push_back('{rw: 1'b1, addr: 30'h604, data: 32'h22222222});
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL bb_gap got=%b want=1", bus_req_); end
    total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL bb_gap_busy got=%b want=1", cpu_busy); end
    next_cycle();
    cpu_req = 1'b0; bus_grnt_ = 1'b0;
    sample();
    total++; if (bus_req_ !== 1'b0) begin bad++; $display("FAIL bb_req2 got=%b want=0", bus_req_); end
    next_cycle();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h22222222;
    sample();
    e = sb_q.pop_front();
    total++; if (bus_addr !== e.addr) begin bad++; $display("FAIL bb_addr2 got=%h want=%h", bus_addr, e.addr); end
    total++; if (cpu_rd_data !== e.data) begin bad++; $display("FAIL bb_data2 got=%h want=%h", cpu_rd_data, e.data); end
    next_cycle();
    bus_rdy_ = 1'b1; bus_rd_data = '0;
    sample();
    total++; if (bus_req_ !== 1'b1) begin bad++; $display("FAIL bb_release got=%b want=1", bus_req_); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_flush();
    test_stall();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
